// File: rtl/mux_arb_rr.sv
// Registered CHANNELS-to-1 valid/ready multiplexer with round-robin or fixed-priority
// arbitration, an optional grant lock, and a single-entry output register.
module mux_arb_rr #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int PRIO_MODE = 0,
  localparam int SEL_W    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      lock,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    win_idx;
  logic [CHANNELS-1:0] grant;
  logic                any_valid;
  logic                load_en;
  logic                in_xfer;

  // Winner index; meaningful only while any_valid is high.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    win_idx = '0;
    if (lock && in_valid[ptr]) begin
      win_idx = ptr;
    end else if (PRIO_MODE != 0) begin
      // Scan high to low so the lowest valid index is the last write and wins.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) win_idx = SEL_W'(i);
      end
    end else begin
      // Scan furthest to nearest from ptr+1 so the nearest valid channel wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        if (in_valid[(int'(ptr) + k) % CHANNELS]) begin
          win_idx = SEL_W'((int'(ptr) + k) % CHANNELS);
        end
      end
    end
  end

  assign any_valid = |in_valid;

  always_comb begin
    grant          = '0;
    grant[win_idx] = any_valid;
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (reset || !load_en) ? '0 : grant;
  assign in_xfer  = |(in_valid & in_ready);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(win_idx)*WIDTH +: WIDTH];
      out_sel   <= win_idx;
      ptr       <= win_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Bench for mux_arb_rr: a round-robin and a fixed-priority instance share stimulus and are
// compared with a transaction-level reference model plus directed scenario expectations.
module tb_mux_arb_rr;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic             lock;
  logic             out_ready;

  logic [NCH-1:0] rr_in_ready, fp_in_ready;
  logic [W-1:0]   rr_out_data, fp_out_data;
  logic [1:0]     rr_out_sel, fp_out_sel;
  logic           rr_out_valid, fp_out_valid;

  mux_arb_rr #(.WIDTH(W), .CHANNELS(NCH), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rr_in_ready),
    .lock(lock), .out_data(rr_out_data), .out_sel(rr_out_sel), .out_valid(rr_out_valid),
    .out_ready(out_ready)
  );

  mux_arb_rr #(.WIDTH(W), .CHANNELS(NCH), .PRIO_MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(fp_in_ready),
    .lock(lock), .out_data(fp_out_data), .out_sel(fp_out_sel), .out_valid(fp_out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [W-1:0] o_data [2];
  logic [1:0]   o_sel  [2];
  logic         o_valid[2];
  assign o_data[0] = rr_out_data;  assign o_data[1] = fp_out_data;
  assign o_sel[0]  = rr_out_sel;   assign o_sel[1]  = fp_out_sel;
  assign o_valid[0] = rr_out_valid; assign o_valid[1] = fp_out_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed priority.
  bit           m_valid[2] = '{0, 0};
  logic [W-1:0] m_data [2] = '{0, 0};
  logic [1:0]   m_sel  [2] = '{0, 0};
  int           m_ptr  [2] = '{NCH - 1, NCH - 1};
  logic [NCH-1:0] exp_rdy[2];
  logic [NCH-1:0] obs_rdy[2];

  // Which channel the arbitration rules pick, or -1 when nothing is valid.
  function automatic int pick(int mode, int ptr, logic [NCH-1:0] v, logic lk);
    if (lk && v[ptr]) return ptr;
    if (mode == 1) begin
      for (int i = 0; i < NCH; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= NCH; k++) if (v[(ptr + k) % NCH]) return (ptr + k) % NCH;
    end
    return -1;
  endfunction

  // Inputs are already set; predicts in_ready, samples it, clocks DUT and model together.
  task automatic tick();
    int w;
    for (int m = 0; m < 2; m++) begin
      w = pick(m, m_ptr[m], in_valid, lock);
      exp_rdy[m] = '0;
      if (!reset && (!m_valid[m] || out_ready) && w >= 0) exp_rdy[m][w] = 1'b1;
    end
    #1;
    obs_rdy[0] = rr_in_ready;
    obs_rdy[1] = fp_in_ready;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      w = pick(m, m_ptr[m], in_valid, lock);
      if (reset) begin
        m_valid[m] = 0; m_data[m] = '0; m_sel[m] = '0; m_ptr[m] = NCH - 1;
      end else if (exp_rdy[m] != '0) begin
        m_valid[m] = 1; m_data[m] = in_data[w*W +: W]; m_sel[m] = 2'(w); m_ptr[m] = w;
      end else if (m_valid[m] && out_ready) begin
        m_valid[m] = 0;
      end
    end
    #1;
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < NCH; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);
  endtask

  task automatic do_reset();
    reset = 1'b1; lock = 1'b0; out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; lock = 1'b0;
    set_fixed_data();
    repeat (2) begin
      tick();
      checks++;
      if (obs_rdy[0] !== 4'b0000 || obs_rdy[1] !== 4'b0000) begin
        errors++;
        $display("FAIL reset_in_ready: got rr=%b fp=%b, want 0000", obs_rdy[0], obs_rdy[1]);
      end
      checks++;
      if (rr_out_valid !== 1'b0 || rr_out_data !== '0 || rr_out_sel !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b data=%h sel=%0d, want 0 0 0",
                 rr_out_valid, rr_out_data, rr_out_sel);
      end
    end
    reset = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (o_valid[m] !== 1'b1 || o_sel[m] !== 2'd0 || o_data[m] !== 32'hA0) begin
        errors++;
        $display("FAIL first_after_reset[%0d]: got valid=%b sel=%0d data=%h, want 1 0 a0",
                 m, o_valid[m], o_sel[m], o_data[m]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [6] = '{0, 1, 2, 3, 0, 1};
    set_fixed_data();
    in_valid = 4'b1111;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== seq[i] || rr_out_data !== 32'hA0 + 32'(seq[i])) begin
        errors++;
        $display("FAIL rr_fairness step %0d: got valid=%b sel=%0d data=%h, want sel=%0d",
                 i, rr_out_valid, rr_out_sel, rr_out_data, seq[i]);
      end
      checks++;
      if (fp_out_sel !== 2'd0) begin
        errors++;
        $display("FAIL fp_all_valid step %0d: got sel=%0d, want 0", i, fp_out_sel);
      end
    end
  endtask

  task automatic test_backpressure();
    set_fixed_data();
    in_valid = 4'b1111;
    do_reset();
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (obs_rdy[0] !== 4'b0000 || rr_out_valid !== 1'b1 || rr_out_sel !== 2'd0 ||
          rr_out_data !== 32'hA0) begin
        errors++;
        $display("FAIL backpressure_hold: got in_ready=%b valid=%b sel=%0d data=%h, want 0000 1 0 a0",
                 obs_rdy[0], rr_out_valid, rr_out_sel, rr_out_data);
      end
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'(i) || rr_out_data !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL backpressure_release %0d: got valid=%b sel=%0d data=%h, want sel=%0d",
                 i, rr_out_valid, rr_out_sel, rr_out_data, i);
      end
    end
  endtask

  task automatic test_fixed_priority();
    set_fixed_data();
    in_valid = 4'b1010;
    do_reset();
    repeat (4) begin
      tick();
      checks++;
      if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd1 || fp_out_data !== 32'hA1) begin
        errors++;
        $display("FAIL fixed_prio_ch1: got valid=%b sel=%0d data=%h, want 1 1 a1",
                 fp_out_valid, fp_out_sel, fp_out_data);
      end
    end
    in_valid = 4'b1000;
    tick();
    checks++;
    if (fp_out_valid !== 1'b1 || fp_out_sel !== 2'd3 || fp_out_data !== 32'hA3) begin
      errors++;
      $display("FAIL fixed_prio_ch3: got valid=%b sel=%0d data=%h, want 1 3 a3",
               fp_out_valid, fp_out_sel, fp_out_data);
    end
  endtask

  task automatic test_lock();
    set_fixed_data();
    in_valid = 4'b1111;
    do_reset();
    repeat (3) tick();
    checks++;
    if (rr_out_sel !== 2'd2) begin
      errors++;
      $display("FAIL lock_setup: got sel=%0d, want 2", rr_out_sel);
    end
    lock = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd2 || rr_out_data !== 32'hA2) begin
        errors++;
        $display("FAIL lock_hold: got valid=%b sel=%0d data=%h, want 1 2 a2",
                 rr_out_valid, rr_out_sel, rr_out_data);
      end
    end
    in_valid = 4'b1011;
    tick();
    checks++;
    if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd3 || rr_out_data !== 32'hA3) begin
      errors++;
      $display("FAIL lock_release: got valid=%b sel=%0d data=%h, want 1 3 a3",
               rr_out_valid, rr_out_sel, rr_out_data);
    end
    lock = 1'b0;
  endtask

  task automatic test_sparse_wrap();
    logic [1:0] seq [4] = '{0, 3, 0, 3};
    set_fixed_data();
    in_valid = 4'b1001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== seq[i]) begin
        errors++;
        $display("FAIL sparse_wrap step %0d: got valid=%b sel=%0d, want 1 %0d",
                 i, rr_out_valid, rr_out_sel, seq[i]);
      end
    end
    repeat (3) begin
      in_valid = 4'b0010;
      tick();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_sel !== 2'd1 || rr_out_data !== 32'hA1) begin
        errors++;
        $display("FAIL pulse_once: got valid=%b sel=%0d data=%h, want 1 1 a1",
                 rr_out_valid, rr_out_sel, rr_out_data);
      end
      in_valid = 4'b0000;
      tick();
      checks++;
      if (rr_out_valid !== 1'b0 || rr_out_sel !== 2'd1) begin
        errors++;
        $display("FAIL pulse_no_dup: got valid=%b sel=%0d, want 0 1", rr_out_valid, rr_out_sel);
      end
    end
  endtask

  task automatic test_random();
    in_valid = '0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NCH; i++) in_data[i*W +: W] = $urandom;
      in_valid  = 4'($urandom);
      lock      = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 63) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_rdy[m] !== exp_rdy[m]) begin
          errors++;
          $display("FAIL rand_in_ready[%0d] cycle %0d: got %b, want %b", m, n, obs_rdy[m], exp_rdy[m]);
        end
        checks++;
        if (o_valid[m] !== m_valid[m] || o_sel[m] !== m_sel[m] || o_data[m] !== m_data[m]) begin
          errors++;
          $display("FAIL rand_out[%0d] cycle %0d: got valid=%b sel=%0d data=%h, want valid=%b sel=%0d data=%h",
                   m, n, o_valid[m], o_sel[m], o_data[m], m_valid[m], m_sel[m], m_data[m]);
        end
      end
    end
    reset = 1'b0;
    lock  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; lock = 1'b0; out_ready = 1'b1; in_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fixed_priority();
    test_lock();
    test_sparse_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
